// File: rtl/core_pkg.sv
// Shared execute-stage types for the iterative divider.
package core_pkg;

    // RV32M divide flavours, encoded as they arrive from the decoder
    typedef enum logic [1:0] {
        DIV_S = 2'b00,
        DIV_U = 2'b01,
        REM_S = 2'b10,
        REM_U = 2'b11
    } div_op_t;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // DIV and REM work on magnitudes and fix the signs afterwards
    function automatic logic op_is_signed(div_op_t op);
        return (op == DIV_S) || (op == REM_S);
    endfunction

    // REM/REMU return the remainder, DIV/DIVU the quotient
    function automatic logic op_is_rem(div_op_t op);
        return (op == REM_S) || (op == REM_U);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
// The quotient register doubles as the dividend shift register: its MSB is
// shifted into the partial remainder and the new quotient bit enters at the LSB.
module div_step
    import core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] trial;
    logic             restore;

    // Shift, trial-subtract, and restore when the difference goes negative
    always_comb begin
        trial   = {rem_in, quo_in[WIDTH-1]} - {2'b00, divisor};
        restore = trial[WIDTH+1];
        rem_out = restore ? {rem_in[WIDTH-1:0], quo_in[WIDTH-1]} : trial[WIDTH:0];
        quo_out = {quo_in[WIDTH-2:0], ~restore};
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// Signed operations divide magnitudes; the quotient is negated when operand
// signs differ and the remainder follows the dividend sign. Divide-by-zero and
// signed overflow bypass the iteration and finish in a single cycle.
module iter_divider
    import core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic [1:0]       DivOpE,
    input  logic [WIDTH-1:0] Op1E,
    input  logic [WIDTH-1:0] Op2E,
    input  logic             KillE,
    output logic             BusyE,
    output logic             DoneE,
    output logic [WIDTH-1:0] DivResultE
);

    localparam int               CNT_W   = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    // Absolute value for signed ops; the most negative value maps to itself,
    // which is its correct unsigned magnitude
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? ~v + 1'b1 : v;
    endfunction

    // Two's-complement sign restore for the post-processing step
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? ~v + 1'b1 : v;
    endfunction

    div_state_t              state, state_next;
    div_op_t                 op_in, op_p0;
    logic [CNT_W-1:0]        cnt_p0;
    logic [WIDTH:0]          rem_p0;
    logic [WIDTH-1:0]        quo_p0;
    logic [WIDTH-1:0]        dvs_p0;
    logic [WIDTH-1:0]        result_p0;
    logic                    neg_q_p0;
    logic                    neg_r_p0;

    logic signed [WIDTH-1:0] op1_s;
    logic signed [WIDTH-1:0] op2_s;
    logic                    in_signed;
    logic                    accept;
    logic                    div_zero;
    logic                    overflow;
    logic                    special;
    logic [WIDTH-1:0]        special_res;
    logic                    last_step;
    logic [WIDTH:0]          step_rem;
    logic [WIDTH-1:0]        step_quo;
    logic [WIDTH-1:0]        final_res;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_p0),
        .quo_in  (quo_p0),
        .divisor (dvs_p0),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Start acceptance, special-case detect and final sign correction
    always_comb begin
        op_in     = div_op_t'(DivOpE);
        op1_s     = Op1E;
        op2_s     = Op2E;
        in_signed = op_is_signed(op_in);
        accept    = StartE && !KillE && ((state == IDLE) || (state == DONE));
        div_zero  = (Op2E == '0);
        overflow  = in_signed && (Op1E == MIN_VAL) && (Op2E == '1);
        special   = div_zero || overflow;
        if (div_zero) begin
            special_res = op_is_rem(op_in) ? Op1E : '1;
        end else begin
            special_res = op_is_rem(op_in) ? '0 : MIN_VAL;
        end
        last_step = (cnt_p0 == CNT_W'(1));
        final_res = op_is_rem(op_p0) ? apply_sign(step_rem[WIDTH-1:0], neg_r_p0)
                                     : apply_sign(step_quo, neg_q_p0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs; a kill overrides everything
    always_comb begin
        state_next = state;
        BusyE      = 1'b0;
        DoneE      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = special ? DONE : CALC;
            end
            CALC: begin
                BusyE = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                DoneE = 1'b1;
                if (accept) state_next = special ? DONE : CALC;
                else        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (KillE) state_next = IDLE;
    end

    // Operand capture, one restoring step per CALC cycle, result on entry to DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            op_p0     <= DIV_S;
            cnt_p0    <= '0;
            rem_p0    <= '0;
            quo_p0    <= '0;
            dvs_p0    <= '0;
            result_p0 <= '0;
            neg_q_p0  <= 1'b0;
            neg_r_p0  <= 1'b0;
        end else if (KillE) begin
            // abandoned divide: leave the visible result untouched
        end else if (accept) begin
            op_p0    <= op_in;
            cnt_p0   <= CNT_W'(WIDTH);
            rem_p0   <= '0;
            quo_p0   <= magnitude(op1_s, in_signed);
            dvs_p0   <= magnitude(op2_s, in_signed);
            neg_q_p0 <= in_signed && (Op1E[WIDTH-1] ^ Op2E[WIDTH-1]);
            neg_r_p0 <= in_signed && Op1E[WIDTH-1];
            if (special) result_p0 <= special_res;
        end else if (state == CALC) begin
            rem_p0 <= step_rem;
            quo_p0 <= step_quo;
            cnt_p0 <= cnt_p0 - CNT_W'(1);
            if (last_step) result_p0 <= final_res;
        end
    end

    assign DivResultE = result_p0;

endmodule

// File: tb/tb_iter_divider.sv
// Randomised and directed scoreboard bench for iter_divider.
module tb_iter_divider;

    localparam int               W       = 32;
    localparam logic [W-1:0]     MIN_VAL = 32'h8000_0000;
    localparam logic [1:0]       OP_DIV  = 2'b00;
    localparam logic [1:0]       OP_DIVU = 2'b01;
    localparam logic [1:0]       OP_REM  = 2'b10;
    localparam logic [1:0]       OP_REMU = 2'b11;

    logic         clk = 1'b0;
    logic         reset;
    logic         StartE;
    logic [1:0]   DivOpE;
    logic [W-1:0] Op1E;
    logic [W-1:0] Op2E;
    logic         KillE;
    logic         BusyE;
    logic         DoneE;
    logic [W-1:0] DivResultE;

    iter_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .StartE     (StartE),
        .DivOpE     (DivOpE),
        .Op1E       (Op1E),
        .Op2E       (Op2E),
        .KillE      (KillE),
        .BusyE      (BusyE),
        .DoneE      (DoneE),
        .DivResultE (DivResultE)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] held = '0;
    int           busy_from = -1;
    int           busy_to = -2;
    bit           mon_en = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: RISC-V division rules expressed with plain SV arithmetic
    function automatic logic [W-1:0] ref_div(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic                is_rem;
        logic                is_sgn;
        sa     = a;
        sb     = b;
        is_rem = op[1];
        is_sgn = !op[0];
        if (b == '0) return is_rem ? a : '1;
        if (is_sgn && a == MIN_VAL && b == '1) return is_rem ? '0 : MIN_VAL;
        case (op)
            OP_DIV:  return sa / sb;
            OP_DIVU: return a / b;
            OP_REM:  return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
        return (b == '0) || (!op[0] && a == MIN_VAL && b == '1);
    endfunction

    // Monitor: compares every cycle against the scoreboard and the held-value model
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", W'(BusyE), W'(cyc >= busy_from && cyc <= busy_to));
            if (DoneE === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got DoneE=1, expected none (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("result", DivResultE, e.res);
                    check("done_cycle", W'(cyc), W'(e.cyc));
                    held = e.res;
                end
            end else begin
                check("held", DivResultE, held);
                if (sbq.size() > 0 && cyc >= sbq[0].cyc) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL missing_done: got no DoneE, expected one by cycle %0d (cycle %0d)",
                             sbq[0].cyc, cyc);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        bit   sp;
        sp     = is_special(op, a, b);
        e.res  = ref_div(op, a, b);
        e.cyc  = sp ? cyc + 1 : cyc + W + 1;
        sbq.push_back(e);
        if (!sp) begin
            busy_from = cyc + 1;
            busy_to   = cyc + W;
        end
        StartE = 1'b1;
        DivOpE = op;
        Op1E   = a;
        Op2E   = b;
        step();
        StartE = 1'b0;
    endtask

    task automatic wait_done();
        int target;
        if (sbq.size() == 0) return;
        target = sbq[$].cyc;
        while (cyc < target) step();
    endtask

    task automatic kill_now();
        KillE = 1'b1;
        step();
        KillE = 1'b0;
        sbq.delete();
        busy_from = -1;
        busy_to   = -2;
    endtask

    task automatic reset_now();
        reset = 1'b1;
        step();
        reset = 1'b0;
        sbq.delete();
        busy_from = -1;
        busy_to   = -2;
        held      = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        reset  = 1'b1;
        StartE = 1'b0;
        KillE  = 1'b0;
        DivOpE = '0;
        Op1E   = '0;
        Op2E   = '0;
        repeat (3) step();
        check("rst_busy", W'(BusyE), '0);
        check("rst_done", W'(DoneE), '0);
        check("rst_result", DivResultE, '0);
        mon_en = 1'b1;
        reset  = 1'b0;
        step();

        // Directed arithmetic and special cases
        issue(OP_DIVU, 100, 7);            wait_done(); step();
        issue(OP_REMU, 100, 7);            wait_done(); step();
        issue(OP_DIV, -32'sd7, 2);         wait_done(); step();
        issue(OP_REM, -32'sd7, 2);         wait_done(); step();
        issue(OP_REM, 7, -32'sd2);         wait_done(); step();
        issue(OP_DIVU, 5, 0);              wait_done(); step();
        issue(OP_REM, 5, 0);               wait_done(); step();
        issue(OP_DIV, MIN_VAL, '1);        wait_done(); step();
        issue(OP_REM, MIN_VAL, '1);        wait_done(); step();

        // Kill in CALC cycle 10: no DoneE, result holds
        issue(OP_DIVU, 1000, 3);
        repeat (9) step();
        kill_now();
        repeat (3) step();

        // Reset in CALC cycle 10: all outputs clear
        issue(OP_DIVU, 1000, 3);
        repeat (9) step();
        reset_now();
        repeat (3) step();

        // Back-to-back start from DONE, plus an ignored start mid-CALC
        issue(OP_DIVU, 50, 5);
        wait_done();
        issue(OP_DIVU, 9, 3);
        repeat (5) step();
        StartE = 1'b1;
        DivOpE = OP_REMU;
        Op1E   = 32'h1234_5678;
        Op2E   = '0;
        step();
        StartE = 1'b0;
        wait_done();
        step();

        // Randomised mix, sometimes back-to-back
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = '0;
                1: begin a = MIN_VAL; b = '1; end
                2: b = W'($urandom_range(1, 15));
                3: a = W'($urandom_range(0, 100));
                4: b = -W'($urandom_range(1, 15));
                default: ;
            endcase
            issue(op, a, b);
            wait_done();
            if ($urandom_range(0, 1) == 1) step();
        end

        repeat (3) step();
        check("queue_empty", W'(sbq.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
